// File: rtl/img_pkt_pkg.sv
// Shared definitions for the camera frame pack/unpack path: header word,
// FSM state encoding and line-geometry derivations.
package img_pkt_pkg;

    localparam logic [31:0] IMG_FRAME_HEAD_DEF = 32'hf05aa50f;

    typedef enum logic [2:0] {
        IDLE,
        FSTART,
        HEAD,
        LREQ,
        LINE,
        DONE
    } state_t;

    // Bytes carried by one image line.
    function automatic int unsigned line_bytes(input int unsigned h_pixel,
                                               input int unsigned bpp);
        return h_pixel * bpp;
    endfunction

    // 64-bit DDR words per line; the line byte count must be a multiple of 8.
    function automatic int unsigned words_per_line(input int unsigned h_pixel,
                                                   input int unsigned bpp);
        return line_bytes(h_pixel, bpp) / 8;
    endfunction

endpackage

// File: rtl/img_frame_unpack_tx_if.sv
// Valid/ready stream bundle with an end-of-frame marker, used for both the
// 64-bit DDR word side and the byte-wide transmit side.
interface img_frame_unpack_tx_if #(
    parameter int unsigned DW = 8
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/img_frame_unpack_tx_unpack.sv
// 64->8 unpacker: one holding register emitted MSB byte first, refilled in the
// same cycle its final byte leaves so back-to-back words stream without bubbles.
module word_to_byte_unpack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        out_last
);

    logic [63:0] hold;
    logic [2:0]  idx;
    logic        full;

    assign out_valid = full;
    assign out_data  = hold[63:56];
    assign out_last  = full & (idx == 3'd7);
    assign in_ready  = ~full | (out_last & out_ready);

    // Holding register: load on accept, shift left one byte per accepted output byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else if (in_valid && in_ready) begin
            hold <= in_data;
            idx  <= '0;
            full <= 1'b1;
        end else if (full && out_ready) begin
            if (idx == 3'd7) begin
                hold <= '0;
                full <= 1'b0;
            end else begin
                hold <= {hold[55:0], 8'h00};
                idx  <= idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/img_frame_unpack_tx.sv
// Frame readback transmitter: header, per-line DDR requests and byte unpacking
// of the stored frame onto the host byte stream.
module img_frame_unpack_tx
    import img_pkt_pkg::*;
#(
    parameter logic [31:0] IMG_FRAME_HEAD  = IMG_FRAME_HEAD_DEF,
    parameter logic [15:0] CMOS_H_PIXEL    = 16'd640,
    parameter logic [15:0] CMOS_V_PIXEL    = 16'd480,
    parameter int unsigned BYTES_PER_PIXEL = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_start,
    output logic                        line_req,
    output logic                        frame_done,
    img_frame_unpack_tx_if.slave        word,
    img_frame_unpack_tx_if.master       tx
);

    localparam logic [15:0] WPL =
        16'(words_per_line(32'(CMOS_H_PIXEL), BYTES_PER_PIXEL));

    state_t      state, state_next;
    logic [1:0]  hcnt;
    logic [15:0] word_cnt;
    logic [15:0] line_cnt;

    logic        in_line;
    logic        allow;
    logic        unp_in_ready;
    logic        unp_out_valid;
    logic [7:0]  unp_out_data;
    logic        unp_out_last;
    logic        word_take;
    logic        last_word;
    logic        last_line;
    logic        line_end;
    logic [7:0]  head_byte;

    assign in_line   = (state == LINE);
    assign allow     = in_line & (word_cnt < WPL);
    assign word.ready = unp_in_ready & allow;
    assign word_take = word.valid & word.ready;
    // Once all words of the line are taken, the holding register holds the last one.
    assign last_word = (word_cnt == WPL);
    assign last_line = (line_cnt == CMOS_V_PIXEL - 16'd1);
    assign line_end  = in_line & unp_out_valid & unp_out_last & tx.ready & last_word;

    word_to_byte_unpack u_unpack (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (word.valid & allow),
        .in_data   (word.data),
        .in_ready  (unp_in_ready),
        .out_valid (unp_out_valid),
        .out_data  (unp_out_data),
        .out_ready (tx.ready & in_line),
        .out_last  (unp_out_last)
    );

    // Header byte select, MSB first.
    always_comb begin
        head_byte = IMG_FRAME_HEAD[31:24];
        case (hcnt)
            2'd0: head_byte = IMG_FRAME_HEAD[31:24];
            2'd1: head_byte = IMG_FRAME_HEAD[23:16];
            2'd2: head_byte = IMG_FRAME_HEAD[15:8];
            2'd3: head_byte = IMG_FRAME_HEAD[7:0];
            default: head_byte = IMG_FRAME_HEAD[31:24];
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; stream outputs depend only on registered state.
    always_comb begin
        state_next  = state;
        busy        = (state != IDLE);
        frame_start = 1'b0;
        line_req    = 1'b0;
        frame_done  = 1'b0;
        tx.valid    = 1'b0;
        tx.data     = '0;
        tx.last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FSTART;
            end
            FSTART: begin
                frame_start = 1'b1;
                state_next  = HEAD;
            end
            HEAD: begin
                tx.valid = 1'b1;
                tx.data  = head_byte;
                if (tx.ready && hcnt == 2'd3) state_next = LREQ;
            end
            LREQ: begin
                line_req   = 1'b1;
                state_next = LINE;
            end
            LINE: begin
                tx.valid = unp_out_valid;
                tx.data  = unp_out_valid ? unp_out_data : '0;
                tx.last  = unp_out_valid & unp_out_last & last_word & last_line;
                if (line_end) state_next = last_line ? DONE : LREQ;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Header byte, word-per-line and line counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= '0;
            word_cnt <= '0;
            line_cnt <= '0;
        end else begin
            case (state)
                FSTART: begin
                    hcnt     <= '0;
                    line_cnt <= '0;
                end
                HEAD: begin
                    if (tx.ready) hcnt <= hcnt + 2'd1;
                end
                LREQ: begin
                    word_cnt <= '0;
                end
                LINE: begin
                    if (word_take) word_cnt <= word_cnt + 16'd1;
                    if (line_end)  line_cnt <= line_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_img_frame_unpack_tx.sv
// Directed bench for img_frame_unpack_tx: a tiny 8x2 frame instance for stream
// content, backpressure, line-end, start-filter and reset cases, plus a 32x4
// instance for line/word/byte accounting.
`timescale 1ns/1ps
module tb_img_frame_unpack_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, frame_start, line_req, frame_done;

    logic start2 = 1'b0;
    logic busy2, frame_start2, line_req2, frame_done2;

    int total = 0;
    int bad = 0;

    img_frame_unpack_tx_if #(.DW(64)) w_if ();
    img_frame_unpack_tx_if #(.DW(8))  t_if ();
    img_frame_unpack_tx_if #(.DW(64)) w2_if ();
    img_frame_unpack_tx_if #(.DW(8))  t2_if ();

    img_frame_unpack_tx #(
        .CMOS_H_PIXEL   (16'd8),
        .CMOS_V_PIXEL   (16'd2),
        .BYTES_PER_PIXEL(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .frame_start(frame_start),
        .line_req   (line_req),
        .frame_done (frame_done),
        .word       (w_if.slave),
        .tx         (t_if.master)
    );

    img_frame_unpack_tx #(
        .CMOS_H_PIXEL   (16'd32),
        .CMOS_V_PIXEL   (16'd4),
        .BYTES_PER_PIXEL(2)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .busy       (busy2),
        .frame_start(frame_start2),
        .line_req   (line_req2),
        .frame_done (frame_done2),
        .word       (w2_if.slave),
        .tx         (t2_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] make_word(input int k);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < 8; b++) w[63-8*b -: 8] = 8'(8*k + b);
        return w;
    endfunction

    // Word sources: word k carries bytes 8k..8k+7, restarted at each frame_start.
    int src_idx = 0;
    int src2_idx = 0;
    bit take1, take2;
    assign w_if.data  = make_word(src_idx);
    assign w2_if.data = make_word(src2_idx);

    always @(posedge clk) begin
        #1;
        if (take1) src_idx++;
        if (take2) src2_idx++;
    end

    // Random backpressure on the small instance.
    bit bp_en = 0;
    always @(posedge clk) begin
        #1;
        if (bp_en) t_if.ready = 1'($urandom_range(0, 1));
    end

    // Monitor for the small instance, sampled mid-cycle.
    int fs_cnt = 0, lreq_cnt = 0, fd_cnt = 0, line_takes = 0, over_take = 0, stall_bad = 0;
    logic [7:0] rx_q[$];
    bit last_q[$];
    bit stall_prev = 0;
    logic [7:0] prev_data;
    logic prev_last;
    always @(negedge clk) begin
        take1 = w_if.valid & w_if.ready;
        if (frame_start) begin fs_cnt++; src_idx = 0; end
        if (line_req) begin lreq_cnt++; line_takes = 0; end
        if (frame_done) fd_cnt++;
        if (w_if.valid && w_if.ready) begin
            line_takes++;
            if (line_takes > 2) over_take++;
        end
        if (t_if.valid && t_if.ready) begin
            rx_q.push_back(t_if.data);
            last_q.push_back(t_if.last);
        end
        if (stall_prev && rst_n) begin
            if (t_if.valid !== 1'b1 || t_if.data !== prev_data || t_if.last !== prev_last)
                stall_bad++;
        end
        stall_prev = t_if.valid && !t_if.ready;
        prev_data  = t_if.data;
        prev_last  = t_if.last;
    end

    // Monitor for the 32x4 instance.
    int lreq2 = 0, words2 = 0, bytes2 = 0, fd2 = 0, lastcnt2 = 0, lw2 = 0, max_lw2 = 0;
    logic [7:0] last_byte2 = '0;
    always @(negedge clk) begin
        take2 = w2_if.valid & w2_if.ready;
        if (frame_start2) src2_idx = 0;
        if (line_req2) begin lreq2++; lw2 = 0; end
        if (frame_done2) fd2++;
        if (w2_if.valid && w2_if.ready) begin
            words2++;
            lw2++;
            if (lw2 > max_lw2) max_lw2 = lw2;
        end
        if (t2_if.valid && t2_if.ready) begin
            bytes2++;
            if (t2_if.last) begin lastcnt2++; last_byte2 = t2_if.data; end
        end
    end

    logic [7:0] hd [4] = '{8'hf0, 8'h5a, 8'ha5, 8'h0f};

    task automatic clear_mon();
        rx_q.delete();
        last_q.delete();
        fs_cnt = 0; lreq_cnt = 0; fd_cnt = 0; over_take = 0; stall_bad = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (t_if.valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0b want=0", t_if.valid); end
        total++; if (t_if.data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%02h want=00", t_if.data); end
        total++; if (w_if.ready !== 1'b0) begin bad++; $display("FAIL reset_word_ready got=%0b want=0", w_if.ready); end
        total++; if ({frame_start, line_req, frame_done, t_if.last} !== 4'b0) begin
            bad++; $display("FAIL reset_pulses got=%04b want=0000", {frame_start, line_req, frame_done, t_if.last}); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || t_if.valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset busy=%0b tx_valid=%0b want=0,0", busy, t_if.valid); end
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] e;
        clear_mon();
        // Latency: start sampled at N -> frame_start at N+1 -> header byte at N+2.
        pulse_start();
        @(negedge clk);
        total++; if (frame_start !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL latency_frame_start got fs=%0b busy=%0b want=1,1", frame_start, busy); end
        @(negedge clk);
        total++; if (t_if.valid !== 1'b1 || t_if.data !== 8'hf0) begin
            bad++; $display("FAIL latency_head got valid=%0b data=%02h want 1,f0", t_if.valid, t_if.data); end
        wait_done(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=no frame_done want=frame_done"); end
        repeat (3) @(negedge clk);
        total++; if (rx_q.size() != 36) begin bad++; $display("FAIL basic_len got=%0d want=36", rx_q.size()); end
        for (int j = 0; j < rx_q.size() && j < 36; j++) begin
            e = (j < 4) ? hd[j] : 8'(j - 4);
            total++; if (rx_q[j] !== e || last_q[j] !== (j == 35)) begin
                bad++; $display("FAIL basic_byte[%0d] got=%02h/last%0b want=%02h/last%0b", j, rx_q[j], last_q[j], e, j == 35); end
        end
        total++; if (fs_cnt != 1 || lreq_cnt != 2 || fd_cnt != 1) begin
            bad++; $display("FAIL basic_pulses got fs=%0d lreq=%0d fd=%0d want 1,2,1", fs_cnt, lreq_cnt, fd_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b want=0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] e;
        clear_mon();
        bp_en = 1;
        pulse_start();
        wait_done(1000, ok);
        bp_en = 0;
        @(posedge clk); #1 t_if.ready = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=no frame_done want=frame_done"); end
        total++; if (rx_q.size() != 36) begin bad++; $display("FAIL bp_len got=%0d want=36", rx_q.size()); end
        for (int j = 0; j < rx_q.size() && j < 36; j++) begin
            e = (j < 4) ? hd[j] : 8'(j - 4);
            total++; if (rx_q[j] !== e || last_q[j] !== (j == 35)) begin
                bad++; $display("FAIL bp_byte[%0d] got=%02h/last%0b want=%02h/last%0b", j, rx_q[j], last_q[j], e, j == 35); end
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d changes want=0", stall_bad); end
    endtask

    task automatic test_line_end();
        bit ok;
        clear_mon();
        // word_valid stays high throughout; only 2 words per line may be taken.
        pulse_start();
        wait_done(200, ok);
        repeat (3) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL lineend_timeout got=no frame_done want=frame_done"); end
        total++; if (over_take != 0) begin bad++; $display("FAIL lineend_extra_words got=%0d want=0", over_take); end
        total++; if (src_idx != 4) begin bad++; $display("FAIL lineend_words_total got=%0d want=4", src_idx); end
        total++; if (w_if.ready !== 1'b0) begin bad++; $display("FAIL lineend_ready_idle got=%0b want=0", w_if.ready); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_mon();
        pulse_start();
        repeat (8) @(posedge clk);
        pulse_start();
        wait_done(200, ok);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL startign_timeout got=no frame_done want=frame_done"); end
        total++; if (fs_cnt != 1) begin bad++; $display("FAIL startign_frame_start got=%0d want=1", fs_cnt); end
        total++; if (fd_cnt != 1) begin bad++; $display("FAIL startign_frame_done got=%0d want=1", fd_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL startign_busy got=%0b want=0", busy); end
        total++; if (rx_q.size() != 36) begin bad++; $display("FAIL startign_len got=%0d want=36", rx_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        logic [7:0] e;
        clear_mon();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (line_req) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_no_line_req got=0 want=1"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (t_if.valid !== 1'b0 || t_if.data !== 8'h00 || t_if.last !== 1'b0) begin
            bad++; $display("FAIL rstmid_tx got valid=%0b data=%02h last=%0b want 0,00,0", t_if.valid, t_if.data, t_if.last); end
        total++; if ({busy, frame_start, line_req, frame_done, w_if.ready} !== 5'b0) begin
            bad++; $display("FAIL rstmid_ctrl got=%05b want=00000", {busy, frame_start, line_req, frame_done, w_if.ready}); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        pulse_start();
        wait_done(200, ok);
        repeat (2) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout got=no frame_done want=frame_done"); end
        total++; if (rx_q.size() != 36) begin bad++; $display("FAIL rstmid_len got=%0d want=36", rx_q.size()); end
        for (int j = 0; j < rx_q.size() && j < 36; j++) begin
            e = (j < 4) ? hd[j] : 8'(j - 4);
            total++; if (rx_q[j] !== e) begin
                bad++; $display("FAIL rstmid_byte[%0d] got=%02h want=%02h", j, rx_q[j], e); end
        end
    endtask

    task automatic test_frame_count();
        bit ok;
        ok = 0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_done2) begin ok = 1; break; end
        end
        repeat (3) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL count_timeout got=no frame_done want=frame_done"); end
        total++; if (lreq2 != 4) begin bad++; $display("FAIL count_line_req got=%0d want=4", lreq2); end
        total++; if (words2 != 32 || max_lw2 != 8) begin
            bad++; $display("FAIL count_words got total=%0d per_line=%0d want 32,8", words2, max_lw2); end
        total++; if (bytes2 != 260) begin bad++; $display("FAIL count_bytes got=%0d want=260", bytes2); end
        total++; if (fd2 != 1 || lastcnt2 != 1 || last_byte2 !== 8'hff) begin
            bad++; $display("FAIL count_end got fd=%0d last=%0d byte=%02h want 1,1,ff", fd2, lastcnt2, last_byte2); end
    endtask

    initial begin
        w_if.valid = 1'b1;  w_if.last = 1'b0;  t_if.ready = 1'b1;
        w2_if.valid = 1'b1; w2_if.last = 1'b0; t2_if.ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_line_end();
        test_start_ignored();
        test_reset_mid();
        test_frame_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=still running want=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
